aes_core_arbiter: RTL and testbench

- Shares one AES encryption core (round sequencer plus its ARK/SBT/SHR/MXC units) among NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's 128-bit plaintext, then drives the core's enable, reset and plaintext lines.
- Waits for the core's ready, captures the ciphertext and returns it to the owner with a done/ack handshake.
- Sits between the requester blocks (UART/host command paths) and the single AES core instance.

---
 rtl/aes_core_arbiter.sv | 88 ++++++++
 tb/tb_aes_core_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one AES core among NUM_REQ requesters; define AES_ARB_TIMEOUT_EN for the RUN watchdog
module aes_core_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*128-1:0] req_pt,
   input  logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic [127:0]           ct_out,
   output logic [ID_W-1:0]        owner_id,
   output logic                   busy,
   output logic                   err,
   output logic                   core_En,
   output logic                   core_Rst,
   output logic [127:0]           core_PT,
   input  logic [127:0]           core_CT,
   input  logic                   core_Ry
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [ID_W-1:0] last_grant, pick;
   logic [ID_W:0] cand;
   logic [127:0] pt_arr [NUM_REQ];
   logic owner_ack, timeout;
   assign owner_ack = ack[owner_id];
   always_comb
      for (int i = 0; i < NUM_REQ; i++) pt_arr[i] = req_pt[128*i +: 128];
   // scan downward so the candidate nearest last_grant+1 is the one left standing
   always_comb begin
      pick = '0;
      cand = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = {1'b0, last_grant} + (ID_W+1)'(k);
         cand = (cand >= (ID_W+1)'(NUM_REQ)) ? cand - (ID_W+1)'(NUM_REQ) : cand;
         pick = req[cand[ID_W-1:0]] ? cand[ID_W-1:0] : pick;
      end
   end
`ifdef AES_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   assign timeout = (state == RUN) && !core_Ry && (tcnt == TW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge Clk) begin
      tcnt <= (Rst || state != RUN) ? '0 : tcnt + TW'(1);
      err  <= !Rst && timeout;
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif
   always_ff @(posedge Clk)
      state <= Rst ? IDLE : state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = |req ? LOAD : IDLE;
         LOAD: state_nxt = RUN;
         RUN:  state_nxt = timeout ? IDLE : core_Ry ? DONE : RUN;
         DONE: state_nxt = owner_ack ? IDLE : DONE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         owner_id   <= '0;
         core_PT    <= '0;
         ct_out     <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
      end else begin
         if (state == IDLE && |req) begin
            owner_id <= pick;
            core_PT  <= pt_arr[pick];
         end
         if (state == RUN && core_Ry) ct_out <= core_CT;
         if ((state == DONE && owner_ack) || timeout) last_grant <= owner_id;
      end
   end
   always_comb begin
      gnt      = (state == LOAD) ? NUM_REQ'(1) << owner_id : '0;
      done     = (state == DONE) ? NUM_REQ'(1) << owner_id : '0;
      busy     = state != IDLE;
      core_En  = state == RUN;
      core_Rst = state != RUN;
   end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: transaction-level reference model plus directed and randomized stimulus for aes_core_arbiter
module tb_aes_core_arbiter;
   localparam int NR = 4;
   localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   logic Clk, Rst, busy, err, core_En, core_Rst, core_Ry;
   logic [NR-1:0] req, ack, gnt, done;
   logic [NR*128-1:0] req_pt;
   logic [127:0] ct_out, core_PT, core_CT, pt2, pt4;
   logic [1:0] owner_id;
   int total, bad, ack_mode, lat, run_cnt, n, m_ph, m_own, m_last, c;
   bit chk_en, rnd, hold, found;
   logic [127:0] m_pt, m_ct;
   logic [NR-1:0] m_oh;
   int grants[$];
   int rr_exp[5] = '{0, 1, 2, 3, 0};

   aes_core_arbiter #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
      .Clk(Clk), .Rst(Rst), .req(req), .req_pt(req_pt), .ack(ack), .gnt(gnt), .done(done),
      .ct_out(ct_out), .owner_id(owner_id), .busy(busy), .err(err), .core_En(core_En),
      .core_Rst(core_Rst), .core_PT(core_PT), .core_CT(core_CT), .core_Ry(core_Ry));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [127:0] ct_fn(input logic [127:0] pt);
      return (pt == PT0) ? CT0 : {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // spec-level transaction model: phase 0 idle, 1 granted, 2 core running, 3 result held
   always @(posedge Clk) begin
      if (Rst) begin
         m_ph = 0; m_own = 0; m_last = NR - 1; m_pt = '0; m_ct = '0;
      end else if (m_ph == 0) begin
         if (req != 0) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
               c = (m_last + k) % NR;
               if (!found && req[c]) begin found = 1; m_own = c; end
            end
            m_pt = req_pt[m_own*128 +: 128];
            m_ph = 1;
         end
      end else if (m_ph == 1) m_ph = 2;
      else if (m_ph == 2) begin
         if (core_Ry) begin m_ct = core_CT; m_ph = 3; end
      end else if (ack[m_own]) begin
         m_last = m_own; m_ph = 0;
      end
      m_oh = NR'(1) << m_own;
   end

   always @(negedge Clk) if (chk_en) begin
      chk("gnt", 128'(gnt), 128'(m_ph == 1 ? m_oh : '0));
      chk("done", 128'(done), 128'(m_ph == 3 ? m_oh : '0));
      chk("busy", 128'(busy), 128'(m_ph != 0));
      chk("core_En", 128'(core_En), 128'(m_ph == 2));
      chk("core_Rst", 128'(core_Rst), 128'(m_ph != 2));
      chk("err", 128'(err), 128'(0));
      chk("owner_id", 128'(owner_id), 128'(m_own));
      chk("ct_out", ct_out, m_ct);
      chk("core_PT", core_PT, m_pt);
   end

   task automatic step();
      @(posedge Clk);
      #1;
      run_cnt = core_En ? run_cnt + 1 : 0;
      if (!core_En && rnd) lat = $urandom_range(0, 12);
      core_Ry = core_En ? (run_cnt >= lat) : (rnd && $urandom_range(0, 3) == 0);
      core_CT = ct_fn(core_PT);
      if (gnt != 0) grants.push_back(int'(owner_id));
      for (int i = 0; i < NR; i++) begin
         if (ack_mode == 1) ack[i] = done[i];
         else if (ack_mode == 2) ack[i] = ($urandom_range(0, 2) == 0);
         if (hold && gnt[i]) req_pt[i*128 +: 128] = rnd128();
         if (rnd) begin
            if (gnt[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else req_pt[i*128 +: 128] = rnd128();
            end else if (!req[i] && $urandom_range(0, 7) == 0) begin
               req[i] = 1'b1; req_pt[i*128 +: 128] = rnd128();
            end else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
         end
      end
      if (rnd) Rst = ($urandom_range(0, 299) == 0);
   endtask

   task automatic drain(input string nm);
      n = 0;
      while (busy && n < 200) begin step(); n++; end
      chk(nm, 128'(n < 200), 128'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish t=%0t", $time);
      $fatal(1);
   end

   initial begin
      Rst = 1; req = '0; ack = '0; req_pt = '0; core_Ry = 0; core_CT = '0;
      rnd = 0; hold = 0; ack_mode = 0; lat = 40; run_cnt = 0;
      repeat (3) step();
      chk_en = 1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_core_Rst", 128'(core_Rst), 128'(1));
      chk("rst_core_En", 128'(core_En), 128'(0));
      chk("rst_ct", ct_out, 128'(0));
      chk("rst_pt", core_PT, 128'(0));
      Rst = 0;
      // single request with the reference vector
      req_pt[128 +: 128] = PT0; req = 4'b0010;
      step();
      chk("single_gnt", 128'(gnt), 128'(4'b0010));
      chk("single_owner", 128'(owner_id), 128'(1));
      chk("single_pt", core_PT, PT0);
      req = '0;
      n = 0;
      while (done == 0 && n < 200) begin step(); n++; end
      chk("single_done", 128'(done), 128'(4'b0010));
      chk("single_ct", ct_out, CT0);
      // ack stall with a pending request and a foreign ack
      pt2 = rnd128();
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin req_pt[256 +: 128] = pt2; req[2] = 1'b1; end
         if (i == 8) ack[3] = 1'b1;
         step();
         chk("stall_done", 128'(done), 128'(4'b0010));
         chk("stall_ct", ct_out, CT0);
         chk("stall_gnt", 128'(gnt), 128'(0));
      end
      ack = 4'b1010;
      step();
      ack = '0;
      chk("ack_busy", 128'(busy), 128'(0));
      chk("ack_gnt", 128'(gnt), 128'(0));
      step();
      chk("pend_gnt", 128'(gnt), 128'(4'b0100));
      chk("pend_pt", core_PT, pt2);
      req = '0; core_Ry = 1; lat = 5;
      step();
      chk("early_ry_en", 128'(core_En), 128'(1));
      chk("early_ry_done", 128'(done), 128'(0));
      ack_mode = 1;
      drain("drain_single");
      // round robin from a fresh reset with all requests held
      Rst = 1; step(); Rst = 0;
      grants.delete();
      lat = 3; hold = 1; req = 4'b1111;
      for (int i = 0; i < NR; i++) req_pt[i*128 +: 128] = rnd128();
      n = 0;
      while (grants.size() < 5 && n < 300) begin step(); n++; end
      for (int i = 0; i < 5; i++)
         chk("rr_order", 128'(i < grants.size() ? grants[i] : -1), 128'(rr_exp[i]));
      req = '0; hold = 0;
      drain("drain_rr");
      // reset in the middle of RUN
      lat = 1000000; req_pt[256 +: 128] = rnd128(); req = 4'b0100;
      n = 0;
      while (gnt == 0 && n < 20) begin step(); n++; end
      req = '0;
      repeat (11) step();
      Rst = 1; step(); Rst = 0;
      chk("midrst_busy", 128'(busy), 128'(0));
      chk("midrst_core_Rst", 128'(core_Rst), 128'(1));
      chk("midrst_done", 128'(done), 128'(0));
      pt4 = rnd128(); req_pt[0 +: 128] = pt4; req = 4'b0001;
      step();
      chk("midrst_gnt", 128'(gnt), 128'(4'b0001));
      chk("midrst_pt", core_PT, pt4);
      req = '0; lat = 4;
      drain("drain_midrst");
      // without a ready the core is waited on indefinitely
      lat = 1000000; req = 4'b1000;
      n = 0;
      while (gnt == 0 && n < 20) begin step(); n++; end
      req = '0;
      repeat (100) step();
      chk("hang_busy", 128'(busy), 128'(1));
      chk("hang_en", 128'(core_En), 128'(1));
      Rst = 1; step(); Rst = 0;
      // randomized traffic
      rnd = 1; ack_mode = 2;
      repeat (4000) step();
      rnd = 0; Rst = 0; req = '0; ack_mode = 1; lat = 2;
      step();
      drain("drain_rand");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
